// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the sequential single-precision subtractor.
// Holds the FSM state encoding, IEEE-754 field widths, the exponent bias and
// the canned special results (quiet NaN, signed infinities).
package fp_pkg;

  localparam int EXP_W       = 8;
  localparam int FRAC_W      = 23;
  localparam int MANT_W      = FRAC_W + 1;
  localparam int BIAS        = 127;
  localparam int EXP_SPECIAL = 2 * BIAS + 1;
  localparam int ALIGN_MAX   = 26;
  localparam int CNT_W       = 5;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_POS = 32'h7F80_0000;
  localparam logic [31:0] INF_NEG = 32'hFF80_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    SUB,
    NORM,
    PACK
  } state_t;

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational field splitter for one IEEE-754 single word.
// Ports:
//   word       - packed single-precision value
//   sign       - sign bit
//   expo       - biased exponent field
//   mant       - 24-bit mantissa with the hidden bit restored (0 for zero/denormal)
//   is_zero    - exponent field is 0 (zero or denormal, both treated as zero)
//   is_special - exponent field is all ones (infinity or NaN)
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  expo,
  output logic [MANT_W-1:0] mant,
  output logic              is_zero,
  output logic              is_special
);

  // Denormals are flushed: with a zero exponent the whole mantissa reads as
  // zero, otherwise the implicit leading one is prepended to the fraction.
  always_comb begin
    sign       = word[31];
    expo       = word[30:23];
    is_zero    = (word[30:23] == '0);
    is_special = (word[30:23] == EXP_W'(EXP_SPECIAL));
    mant       = is_zero ? '0 : {1'b1, word[22:0]};
  end

endmodule

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor (a - b),
// truncating, one bit of alignment / normalisation shift per clock.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   start  - request, only looked at while idle
//   a, b   - minuend and subtrahend
//   busy   - high whenever the FSM is not idle
//   done   - one-cycle pulse when result is updated
//   result - registered a - b, held until overwritten by the next operation
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t              state;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic                sx;
  logic                sy;
  logic                rsign;
  logic                nan_flag;
  logic [EXP_W-1:0]    ex;
  logic [MANT_W-1:0]   mx;
  logic [MANT_W-1:0]   my;
  logic [CNT_W-1:0]    cnt;

  logic                ua_sign, ub_sign;
  logic [EXP_W-1:0]    ua_exp, ub_exp;
  logic [MANT_W-1:0]   ua_mant, ub_mant;
  logic                ua_zero, ub_zero;
  logic                ua_special, ub_special;

  logic [EXP_W-1:0]    ea_eff, eb_eff, exp_diff;
  logic                a_is_x;
  logic [CNT_W-1:0]    align_d;
  logic [MANT_W:0]     sum;
  logic                sum_sign;
  logic [31:0]         packed_word;

  fp_unpack u_unpack_a (
    .word       (a_q),
    .sign       (ua_sign),
    .expo       (ua_exp),
    .mant       (ua_mant),
    .is_zero    (ua_zero),
    .is_special (ua_special)
  );

  fp_unpack u_unpack_b (
    .word       (b_q),
    .sign       (ub_sign),
    .expo       (ub_exp),
    .mant       (ub_mant),
    .is_zero    (ub_zero),
    .is_special (ub_special)
  );

  // Operand ordering for LOAD: the operand with the larger exponent becomes X
  // (ties keep a as X), and the alignment distance saturates at 26 because
  // beyond that the smaller mantissa has been shifted out entirely.
  always_comb begin
    ea_eff   = ua_zero ? '0 : ua_exp;
    eb_eff   = ub_zero ? '0 : ub_exp;
    a_is_x   = (ea_eff >= eb_eff);
    exp_diff = a_is_x ? (ea_eff - eb_eff) : (eb_eff - ea_eff);
    align_d  = (exp_diff > EXP_W'(ALIGN_MAX)) ? CNT_W'(ALIGN_MAX)
                                              : exp_diff[CNT_W-1:0];
  end

  // Magnitude add/subtract for the SUB cycle. With unlike signs the smaller
  // mantissa is taken from the larger so the difference never goes negative,
  // and the result takes the sign of whichever magnitude was larger.
  always_comb begin
    sum      = '0;
    sum_sign = sx;
    if (sx == sy) begin
      sum      = {1'b0, mx} + {1'b0, my};
      sum_sign = sx;
    end else if (mx >= my) begin
      sum      = {1'b0, mx} - {1'b0, my};
      sum_sign = sx;
    end else begin
      sum      = {1'b0, my} - {1'b0, mx};
      sum_sign = sy;
    end
  end

  // Final word assembly for PACK. NaN inputs win outright; an empty mantissa
  // or an exponent that underflowed to 0 gives +0; an exponent that carried
  // up to all ones becomes a signed infinity.
  always_comb begin
    packed_word = {rsign, ex, mx[FRAC_W-1:0]};
    if (nan_flag) begin
      packed_word = QNAN;
    end else if ((mx == '0) || (ex == '0)) begin
      packed_word = 32'h0000_0000;
    end else if (ex == EXP_W'(EXP_SPECIAL)) begin
      packed_word = rsign ? INF_NEG : INF_POS;
    end
  end

  // Main sequencer. b is captured with its sign inverted so the rest of the
  // datapath only ever performs a + (-b). ALIGN and NORM move one bit per
  // cycle; NORM always spends one cycle deciding before it shifts, so a value
  // that is already normalised (or zero) leaves NORM after a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sx       <= 1'b0;
      sy       <= 1'b0;
      rsign    <= 1'b0;
      nan_flag <= 1'b0;
      ex       <= '0;
      mx       <= '0;
      my       <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= {~b[31], b[30:0]};
            nan_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (ua_special || ub_special) begin
            nan_flag <= 1'b1;
            state    <= PACK;
          end else begin
            if (a_is_x) begin
              sx <= ua_sign;
              ex <= ea_eff;
              mx <= ua_mant;
              sy <= ub_sign;
              my <= ub_mant;
            end else begin
              sx <= ub_sign;
              ex <= eb_eff;
              mx <= ub_mant;
              sy <= ua_sign;
              my <= ua_mant;
            end
            cnt   <= align_d;
            state <= (align_d == '0) ? SUB : ALIGN;
          end
        end

        ALIGN: begin
          my  <= my >> 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= SUB;
          end
        end

        SUB: begin
          rsign <= sum_sign;
          if (sum[MANT_W]) begin
            mx <= sum[MANT_W:1];
            ex <= ex + EXP_W'(1);
          end else begin
            mx <= sum[MANT_W-1:0];
          end
          state <= NORM;
        end

        NORM: begin
          if ((mx == '0) || mx[MANT_W-1] || (ex == '0)) begin
            state <= PACK;
          end else begin
            mx <= mx << 1;
            ex <= ex - EXP_W'(1);
          end
        end

        PACK: begin
          result   <= packed_word;
          done     <= 1'b1;
          busy     <= 1'b0;
          nan_flag <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: self-checking bench for fp_sub_seq. Directed vectors with
// known answers, reset/abort scenarios, then randomised operands compared
// against an arithmetic reference model of the truncating subtractor.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fails  = 0;

  fp_sub_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequencing itself wedges somewhere.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: exact IEEE field arithmetic on integers, following the
  // subtractor's rules (b negated, larger exponent leads, smaller operand
  // truncated by at most 26 places, carry renormalise, left-normalise until
  // the leading one reaches bit 23 or the exponent runs out, flush to +0).
  function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output int lat);
    int     ea, eb, e_big, e_small, d, n, e;
    longint ma, mb, m_big, m_small, m;
    bit     sa, sb, s_big, s_small, s;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    sa = x[31];
    sb = ~y[31];
    if (ea == 255 || eb == 255) begin
      r   = 32'h7FC0_0000;
      lat = 2;
      return;
    end
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(x[22:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(y[22:0]);
    if (ea >= eb) begin
      e_big = ea; e_small = eb; m_big = ma; m_small = mb; s_big = sa; s_small = sb;
    end else begin
      e_big = eb; e_small = ea; m_big = mb; m_small = ma; s_big = sb; s_small = sa;
    end
    d = e_big - e_small;
    if (d > 26) d = 26;
    m_small = m_small >> d;
    if (s_big == s_small) begin
      m = m_big + m_small; s = s_big;
    end else if (m_big >= m_small) begin
      m = m_big - m_small; s = s_big;
    end else begin
      m = m_small - m_big; s = s_small;
    end
    e = e_big;
    if (m >= (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    n = 0;
    while (m != 0 && m < (longint'(1) << 23) && e != 0) begin
      m = m << 1;
      e = e - 1;
      n = n + 1;
    end
    if (m == 0 || e == 0) r = 32'h0000_0000;
    else if (e == 255)    r = s ? 32'hFF80_0000 : 32'h7F80_0000;
    else                  r = {s, 8'(e), 23'(m)};
    lat = 4 + d + n;
  endfunction

  // Random operand generator biased toward close exponents, with occasional
  // zero/denormal, special and near-maximum exponents.
  function automatic logic [31:0] rand_fp();
    logic [31:0] w;
    int sel;
    w   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0)       w[30:23] = 8'h00;
    else if (sel == 1)  w[30:23] = 8'hFF;
    else if (sel < 10)  w[30:23] = 8'($urandom_range(120, 135));
    else if (sel == 10) w[30:23] = 8'hFE;
    else if (sel == 11) w[30:23] = 8'($urandom_range(1, 3));
    else                w[30:23] = 8'($urandom_range(1, 254));
    return w;
  endfunction

  // One full operation: pulse start, confirm busy, wait (bounded) for done,
  // then check latency, result, busy-low-at-done and that done lasts one cycle.
  task automatic applyStimulus(input string tag, input logic [31:0] ta,
                               input logic [31:0] tbv, input logic [31:0] exp_res,
                               input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk);
    a     = ta;
    b     = tbv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 120 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_idle_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_result_hold"}, result, exp_res);
  endtask

  // Test sequence: reset state, directed known answers, abort and priority
  // scenarios, start-while-busy, then the randomised sweep.
  initial begin
    int          cnt_done;
    int          lat;
    bit          seen;
    logic [31:0] ta, tbv, er;
    int          el;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("cancel_n5", 32'h3F57_6AA4, 32'h3F51_B3F3, 32'h3CB6_D620, 9);
    applyStimulus("equal_zero", 32'h3F57_6AA4, 32'h3F57_6AA4, 32'h0000_0000, 4);
    applyStimulus("align_d1", 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000, 6);
    applyStimulus("carry", 32'h4000_0000, 32'hC000_0000, 32'h4080_0000, 4);
    applyStimulus("nan_in", 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 2);
    applyStimulus("overflow_inf", 32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4);

    // Abort in the middle of normalisation: no done, result cleared.
    @(negedge clk);
    a     = 32'h3F57_6AA4;
    b     = 32'h3F51_B3F3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", result, 32'h0000_0000);
    @(negedge clk);
    rst      = 1'b0;
    cnt_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt_done++;
    end
    checkOutput("abort_no_done", 32'(cnt_done), 32'd0);
    applyStimulus("after_abort", 32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000, 6);

    // Reset and start together: reset wins and the request is lost.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 32'h4000_0000;
    b     = 32'hC000_0000;
    @(posedge clk);
    #1;
    checkOutput("rst_prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_prio_still_idle", 32'(busy), 32'd0);

    // A second start while busy is ignored: one done, first operation's answer.
    @(negedge clk);
    a     = 32'h3F57_6AA4;
    b     = 32'h3F51_B3F3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cnt_done = 0;
    seen     = 1'b0;
    lat      = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        @(negedge clk);
        a     = 32'h3F80_0000;
        b     = 32'h3F00_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      if (done) begin
        cnt_done++;
        if (!seen) begin
          seen = 1'b1;
          lat  = k;
          checkOutput("busy_restart_result", result, 32'h3CB6_D620);
        end
      end
    end
    checkOutput("busy_restart_done_count", 32'(cnt_done), 32'd1);
    checkOutput("busy_restart_latency", 32'(lat), 32'd9);

    // Randomised sweep against the reference model.
    for (int i = 0; i < 200; i++) begin
      ta = rand_fp();
      case ($urandom_range(0, 3))
        0: tbv = rand_fp();
        1: begin
          tbv        = ta;
          tbv[15:0]  = 16'($urandom);
          tbv[31]    = 1'($urandom);
        end
        2: begin
          tbv        = rand_fp();
          tbv[30:23] = ta[30:23];
        end
        default: begin
          tbv       = ta;
          tbv[22:0] = 23'($urandom);
        end
      endcase
      ref_sub(ta, tbv, er, el);
      applyStimulus($sformatf("rnd%0d", i), ta, tbv, er, el);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
